// File: rtl/hex_display_scanner_pkg.sv
// Shared types and constants for the hex display scanner and its decoder.
package hex_disp_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // All-ones anode pattern for n digits (n = 1..8), zero-extended to 8 bits.
  function automatic logic [7:0] ANODE_OFF(input int n);
    return 8'hFF >> (8 - n);
  endfunction

endpackage

// File: rtl/hex_display_scanner_dec.sv
// Hex nibble to active-low 7-segment pattern (bit0 = a .. bit6 = g).
module hex_display_scanner_dec
  import hex_disp_pkg::*;
(
  input  nibble_t    hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_n_o = 7'b1000000;
      4'h1: seg_n_o = 7'b1111001;
      4'h2: seg_n_o = 7'b0100100;
      4'h3: seg_n_o = 7'b0110000;
      4'h4: seg_n_o = 7'b0011001;
      4'h5: seg_n_o = 7'b0010010;
      4'h6: seg_n_o = 7'b0000010;
      4'h7: seg_n_o = 7'b1111000;
      4'h8: seg_n_o = 7'b0000000;
      4'h9: seg_n_o = 7'b0010000;
      4'hA: seg_n_o = 7'b0001000;
      4'hB: seg_n_o = 7'b0000011;
      4'hC: seg_n_o = 7'b1000110;
      4'hD: seg_n_o = 7'b0100001;
      4'hE: seg_n_o = 7'b0000110;
      4'hF: seg_n_o = 7'b0001110;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed, double-buffered NUM_DIGITS-digit 7-segment scanner.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    blank,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [7:0]            AN_OFF8  = ANODE_OFF(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_OFF8[NUM_DIGITS-1:0];
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic                  tick_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic    tc, fb;
  nibble_t sel_nib;
  logic    lz_hide;
  logic [6:0] dec_seg;

  assign tc = (cnt_q == CNT_LAST);
  assign fb = tc && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  // A load landing on the frame boundary goes straight to the display so
  // it is neither lost nor delayed a whole frame.
  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (load) begin
      shadow_d = value_in;
      if (fb) begin
        disp_d = value_in;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (fb && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero;
`endif

  // Walk digits from the top so the running "all higher nibbles zero" flag
  // is ready when the selected digit is reached.
  always_comb begin
    sel_nib = '0;
    lz_hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    hi_zero = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      hi_zero = hi_zero && (disp_q[4*i +: 4] == 4'h0);
`endif
      if (idx_q == IDX_W'(i)) begin
        sel_nib = disp_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lz_hide = (i != 0) && hi_zero;
`endif
      end
    end
  end

  hex_display_scanner_dec u_dec (
    .hex_i   (sel_nib),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    if (blank || lz_hide) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      tick_q   <= fb;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;
  assign pending    = pend_q;

endmodule
